// File: rtl/fifo_pkt_reader_pkg.sv
// Shared types and sizing helpers for the FIFO packet reader.
package fifo_pkt_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 3;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pkt_out_buf.sv
// 3-entry {last, data} register FIFO; head entry is registered, zero-filled when empty.
module pkt_out_buf
  import fifo_pkt_reader_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head_data,
  output logic             head_last
);

  typedef logic [WIDTH:0] ent_t;

  ent_t       mem_q [BUF_DEPTH];
  ent_t       mem_d [BUF_DEPTH];
  logic [1:0] occ_q;
  logic [1:0] occ_d;

  // Pop shifts toward the head and zero-fills the tail, so slots at or above
  // occ always hold zero and the idle head reads as all-zero.
  always_comb begin
    for (int i = 0; i < BUF_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    occ_d = occ_q;
    if (pop) begin
      for (int i = 0; i < BUF_DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      mem_d[BUF_DEPTH-1] = '0;
      occ_d = occ_q - 2'd1;
    end
    if (push) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (2'(i) == occ_d) begin
          mem_d[i] = {push_last, push_data};
        end
      end
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      occ_q <= '0;
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      occ_q <= occ_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = mem_q[0][WIDTH-1:0];
  assign head_last = mem_q[0][WIDTH];

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && !pop && occ_q == 2'(BUF_DEPTH)));
  a_no_underflow: assert property (@(posedge clock) disable iff (reset)
    !(pop && occ_q == 2'd0));

endmodule

// File: rtl/fifo_pkt_reader.sv
// Drains a 1-cycle-latency sync FIFO into a framed valid/ready stream; stops only on packet boundaries.
// Optional statistics counters are built when FIFO_PKT_READER_STATS_EN is defined.
module fifo_pkt_reader
  import fifo_pkt_reader_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int PKT_LEN = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read_en,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic             busy,
  output logic [31:0]      pkt_count,
  output logic [31:0]      stall_count
);

  localparam int             CW       = cnt_width(PKT_LEN);
  localparam logic [CW-1:0] LAST_POS = CW'(PKT_LEN - 1);

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          pend_q, pend_d;
  logic          pend_last_q, pend_last_d;
  logic [CW-1:0] rd_word_q, rd_word_d;
  logic [CW-1:0] tx_word_q, tx_word_d;
  logic          rd_allow;
  logic [1:0]    occ;
  logic [2:0]    inflight;
  logic          xfer;

  function automatic logic [CW-1:0] next_pos(input logic [CW-1:0] p);
    return (p == LAST_POS) ? '0 : p + CW'(1);
  endfunction

  always_comb begin
    rd_allow = 1'b0;
    case (state_q)
      STREAM:  rd_allow = 1'b1;
      DRAIN:   rd_allow = (rd_word_q != '0);
      default: rd_allow = 1'b0;
    endcase
  end

  // occ and pend are both registered, so m_tready never reaches fifo_read_en.
  assign inflight     = {1'b0, occ} + {2'b00, pend_q};
  assign fifo_read_en = !reset && rd_allow && !fifo_empty && (inflight < 3'(BUF_DEPTH));

  assign m_tvalid = (occ != 2'd0);
  assign xfer     = m_tvalid && m_tready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (enable) state_d = STREAM;
      STREAM: if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable) begin
          state_d = STREAM;
        end else if (rd_word_q == '0 && !pend_q && occ == 2'd0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // The last tag travels with the read so the entry carries its own framing.
  always_comb begin
    pend_d      = fifo_read_en;
    pend_last_d = (rd_word_q == LAST_POS);
    rd_word_d   = fifo_read_en ? next_pos(rd_word_q) : rd_word_q;
    tx_word_d   = xfer ? next_pos(tx_word_q) : tx_word_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      rd_word_q   <= '0;
      tx_word_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      rd_word_q   <= rd_word_d;
      tx_word_q   <= tx_word_d;
    end
  end

  assign busy = busy_q;

  pkt_out_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clock     (clock),
    .reset     (reset),
    .push      (pend_q),
    .push_data (fifo_data),
    .push_last (pend_last_q),
    .pop       (xfer),
    .occ       (occ),
    .head_data (m_tdata),
    .head_last (m_tlast)
  );

`ifdef FIFO_PKT_READER_STATS_EN
  logic [31:0] pkt_count_q, pkt_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    pkt_count_d   = pkt_count_q + ((xfer && m_tlast) ? 32'd1 : 32'd0);
    stall_count_d = stall_count_q + ((m_tvalid && !m_tready) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      pkt_count_q   <= pkt_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pkt_count   = pkt_count_q;
  assign stall_count = stall_count_q;
`else
  assign pkt_count   = 32'd0;
  assign stall_count = 32'd0;
`endif

  a_tlast_pos: assert property (@(posedge clock) disable iff (reset)
    m_tvalid |-> (m_tlast == (tx_word_q == LAST_POS)));

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Scoreboard bench: FIFO model feeds the reader, expected beats queued at write time.
module tb_fifo_pkt_reader;

  localparam int W = 10;
  localparam int PL = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic         fifo_empty;
  logic [W-1:0] fifo_data;
  logic         fifo_read_en;
  logic [W-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready;
  logic         busy;
  logic [31:0]  pkt_count;
  logic [31:0]  stall_count;

  always #5 clock = ~clock;

  fifo_pkt_reader #(.WIDTH(W), .PKT_LEN(PL)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_read_en (fifo_read_en),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tlast      (m_tlast),
    .m_tready     (m_tready),
    .busy         (busy),
    .pkt_count    (pkt_count),
    .stall_count  (stall_count)
  );

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           seq = 0;
  int           xfers = 0;
  int           m_pkts = 0;
  int           m_stalls = 0;
  int           ready_mode = 0;
  bit           lat_arm = 0;
  int           rd_cyc = -1;
  int           vld_cyc = -1;
  logic [W-1:0] in_q [$];
  logic [W-1:0] fq [$];
  exp_t         exp_q [$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Packet position is a pure function of how many words were written since reset.
  task automatic put_word(input logic [W-1:0] d);
    exp_t e;
    e.d = d;
    e.l = ((seq % PL) == PL - 1);
    in_q.push_back(d);
    exp_q.push_back(e);
    seq++;
  endtask

  task automatic chk_stats(input string nm);
`ifdef FIFO_PKT_READER_STATS_EN
    chk({nm, "_pkt_count"}, pkt_count, 32'(m_pkts));
    chk({nm, "_stall_count"}, stall_count, 32'(m_stalls));
`else
    chk({nm, "_pkt_count"}, pkt_count, 32'd0);
    chk({nm, "_stall_count"}, stall_count, 32'd0);
`endif
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step(1);
      n++;
    end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  // Source FIFO: one-cycle read latency, one write per cycle from in_q.
  initial begin
    logic rd;
    logic rs;
    fifo_data  = '0;
    fifo_empty = 1'b1;
    forever begin
      @(negedge clock);
      rd = fifo_read_en;
      rs = reset;
      @(posedge clock);
      #1;
      if (rs) begin
        fq.delete();
      end else if (rd && fq.size() != 0) begin
        fifo_data = fq.pop_front();
      end
      if (in_q.size() != 0) fq.push_back(in_q.pop_front());
      fifo_empty = (fq.size() == 0);
    end
  end

  initial begin
    int k = 0;
    m_tready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0: m_tready = 1'b1;
        1: m_tready = ((k % 4) == 0) || ((k % 4) == 3);
        2: m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
      k++;
    end
  end

  initial begin
    bit           prev_stall = 0;
    logic [W-1:0] prev_dat = '0;
    logic         prev_last = 1'b0;
    exp_t         e;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 0;
      end else begin
        if (fifo_empty) chk("no_read_when_empty", {31'd0, fifo_read_en}, 32'd0);
        if (prev_stall) begin
          chk("hold_valid", {31'd0, m_tvalid}, 32'd1);
          chk("hold_data", 32'(m_tdata), 32'(prev_dat));
          chk("hold_last", {31'd0, m_tlast}, {31'd0, prev_last});
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 32'(m_tdata), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", 32'(m_tdata), 32'(e.d));
            chk("beat_last", {31'd0, m_tlast}, {31'd0, e.l});
            xfers++;
            if (e.l) m_pkts++;
          end
        end
        if (m_tvalid && !m_tready) m_stalls++;
        prev_stall = m_tvalid && !m_tready;
        prev_dat   = m_tdata;
        prev_last  = m_tlast;
        if (lat_arm) begin
          if (fifo_read_en && rd_cyc < 0) rd_cyc = cyc;
          if (m_tvalid && vld_cyc < 0) vld_cyc = cyc;
        end
      end
    end
  end

  initial begin
    int x0;
    reset  = 1'b1;
    enable = 1'b0;
    step(3);
    chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
    chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_read_en", {31'd0, fifo_read_en}, 32'd0);
    chk("rst_pkt_count", pkt_count, 32'd0);
    chk("rst_stall_count", stall_count, 32'd0);
    reset = 1'b0;
    step(2);

    // Steady stream of 8 preloaded words.
    for (int i = 1; i <= 8; i++) put_word(W'(i));
    step(12);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_no_read", {31'd0, fifo_read_en}, 32'd0);
    lat_arm = 1;
    enable  = 1'b1;
    wait_drain(60, "steady_drain");
    step(5);
    chk("steady_first_valid_latency", 32'(vld_cyc - rd_cyc), 32'd2);
    chk("steady_busy_hold", {31'd0, busy}, 32'd1);
    chk("steady_fifo_empty", {31'd0, fifo_empty}, 32'd1);
    chk("steady_no_valid", {31'd0, m_tvalid}, 32'd0);
    chk_stats("steady");

    // Backpressure with a 1,0,0,1 ready pattern.
    ready_mode = 1;
    for (int i = 0; i < 12; i++) put_word(W'($urandom));
    wait_drain(300, "bp_drain");
    step(3);
    chk_stats("bp");

    // Sparse source: one word every third cycle.
    ready_mode = 0;
    for (int i = 0; i < 8; i++) begin
      put_word(W'($urandom));
      step(3);
    end
    wait_drain(60, "gap_drain");
    step(3);
    chk_stats("gap");

    // Enable falls part-way into a packet: only that packet completes.
    enable = 1'b0;
    wait_idle(40, "gap_to_idle");
    ready_mode = 3;
    for (int i = 0; i < 10; i++) put_word(W'(10'h100 + i));
    step(12);
    enable = 1'b1;
    step(8);
    chk("drop_busy_stream", {31'd0, busy}, 32'd1);
    enable = 1'b0;
    step(4);
    chk("drop_busy_drain", {31'd0, busy}, 32'd1);
    x0 = xfers;
    ready_mode = 0;
    step(20);
    chk("drop_beats", 32'(xfers - x0), 32'd4);
    chk("drop_busy_idle", {31'd0, busy}, 32'd0);
    chk("drop_fifo_left", 32'(fq.size()), 32'd6);
    chk("drop_exp_left", 32'(exp_q.size()), 32'd6);
    chk_stats("drop");

    // Reset with words buffered and in flight.
    ready_mode = 3;
    enable = 1'b1;
    step(4);
    reset  = 1'b1;
    enable = 1'b0;
    exp_q.delete();
    in_q.delete();
    seq      = 0;
    m_pkts   = 0;
    m_stalls = 0;
    step(1);
    chk("midrst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("midrst_tlast", {31'd0, m_tlast}, 32'd0);
    chk("midrst_tdata", 32'(m_tdata), 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk_stats("midrst");
    reset = 1'b0;
    step(2);
    ready_mode = 2;
    for (int i = 0; i < 8; i++) put_word(W'($urandom));
    enable = 1'b1;
    wait_drain(300, "post_rst_drain");
    step(3);
    enable = 1'b0;
    wait_idle(40, "post_rst_idle");
    chk_stats("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
